// File: rtl/id_issue_ctrl.sv
// ----------------------------------------------------------------------------
// id_issue_ctrl
// ----------------------------------------------------------------------------
// Issue controller for the ID stage. It keeps a busy scoreboard with one bit
// per architectural register, set for every in-flight writer. It blocks issue
// on RAW hazards (rs1/rs2 busy) and WAW hazards (rd busy). It also runs the
// IF->ID->EX valid/ready handshake and sequences the stall and flush states.
// WB writes clear busy bits. x0 never becomes busy.
//
// Configuration macro: ID_ISSUE_WB_BYPASS_EN
//   defined   : a WB write to rN in cycle t makes rN not busy in cycle t, so a
//               dependent instruction issues in t. The datapath forwards the
//               WB data into the source operands.
//   undefined : the hazard check uses the registered busy bits, so the
//               dependent instruction issues in t+1.
//
// Ports
//   clk, rst           clock (rising edge); synchronous active-high reset
//   i_if_valid         IF presents a valid instruction
//   o_id_ready         ID accepts the instruction this cycle (combinational)
//   i_rs1/rs2/rd_addr  decoded register addresses
//   i_uses_rs1/rs2     instruction reads rs1 / rs2
//   i_writes_rd        instruction writes rd
//   o_issue_valid      instruction issued to EX this cycle (combinational)
//   i_ex_ready         EX can accept an instruction
//   i_wb_wr_reg_en     WB register write enable
//   i_wb_wr_reg_addr   WB destination register
//   i_flush            redirect pulse; starts FLUSH_CYC cycles of FLUSH
//   o_stall            high while the controller is in STALL
//   o_busy_vec         scoreboard; bit i set = xi has a pending write
// ----------------------------------------------------------------------------
module id_issue_ctrl #(
    parameter int NREGS     = 32,
    parameter int AW        = 5,
    parameter int FLUSH_CYC = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_if_valid,
    output logic             o_id_ready,
    input  logic [AW-1:0]    i_rs1_addr,
    input  logic [AW-1:0]    i_rs2_addr,
    input  logic [AW-1:0]    i_rd_addr,
    input  logic             i_uses_rs1,
    input  logic             i_uses_rs2,
    input  logic             i_writes_rd,
    output logic             o_issue_valid,
    input  logic             i_ex_ready,
    input  logic             i_wb_wr_reg_en,
    input  logic [AW-1:0]    i_wb_wr_reg_addr,
    input  logic             i_flush,
    output logic             o_stall,
    output logic [NREGS-1:0] o_busy_vec
);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_STALL = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    localparam int CW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

    logic [1:0]       state;
    logic [CW-1:0]    flush_cnt;
    logic [NREGS-1:0] busy;

    logic [NREGS-1:0] wb_clr_mask;
    logic [NREGS-1:0] set_mask;
    logic [NREGS-1:0] busy_chk;
    logic [NREGS-1:0] busy_next;
    logic             hazard;
    logic             go;
    logic             fire;

    // One-hot clear mask for the WB write. x0 is never tracked.
    // NOTE: give every signal a default at the top of an always_comb block.
    // A path that leaves a signal unassigned infers a latch.
    always_comb begin
        wb_clr_mask = '0;
        if (i_wb_wr_reg_en && (i_wb_wr_reg_addr != '0))
            wb_clr_mask[i_wb_wr_reg_addr] = 1'b1;
    end

`ifdef ID_ISSUE_WB_BYPASS_EN
    // A register retiring this cycle already counts as free. Its value is
    // forwarded from WB.
    assign busy_chk = busy & ~wb_clr_mask;
`else
    assign busy_chk = busy;
`endif

    // busy[0] is never set, so x0 operands and rd=x0 never raise a hazard.
    assign hazard = (i_uses_rs1  & busy_chk[i_rs1_addr])
                  | (i_uses_rs2  & busy_chk[i_rs2_addr])
                  | (i_writes_rd & busy_chk[i_rd_addr]);

    // rst gates go so that every handshake output stays low during reset.
    assign go   = ~rst & (state != ST_FLUSH) & ~hazard & i_ex_ready & ~i_flush;
    assign fire = i_if_valid & go;

    always_comb begin
        set_mask = '0;
        if (fire && i_writes_rd && (i_rd_addr != '0))
            set_mask[i_rd_addr] = 1'b1;
    end

    // The set is applied after the clear, so a new writer wins over a
    // retiring writer of the same register.
    assign busy_next = ((busy & ~wb_clr_mask) | set_mask) & ~NREGS'(1);

    // NOTE: sequential state uses non-blocking assignments only. All flops
    // then sample pre-edge values and simulation order cannot matter.
    // The scoreboard is a flop vector rather than a RAM, so resetting it
    // costs nothing special.
    always_ff @(posedge clk) begin
        if (rst)
            busy <= '0;
        else
            busy <= busy_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_RUN;
            flush_cnt <= '0;
        end else if (i_flush) begin
            // A flush in any state, including FLUSH, restarts the count.
            state     <= ST_FLUSH;
            flush_cnt <= CW'(FLUSH_CYC - 1);
        end else begin
            case (state)
                ST_RUN: begin
                    if (i_if_valid && !go)
                        state <= ST_STALL;
                end
                ST_STALL: begin
                    if (go || !i_if_valid)
                        state <= ST_RUN;
                end
                ST_FLUSH: begin
                    if (flush_cnt == '0)
                        state <= ST_RUN;
                    else
                        flush_cnt <= flush_cnt - CW'(1);
                end
                default: state <= ST_RUN;
            endcase
        end
    end

    assign o_id_ready    = go;
    assign o_issue_valid = fire;
    assign o_stall       = ~rst & (state == ST_STALL);
    assign o_busy_vec    = rst ? '0 : busy;

endmodule

// File: tb/tb_id_issue_ctrl.sv
// ----------------------------------------------------------------------------
// tb_id_issue_ctrl
// ----------------------------------------------------------------------------
// Self-checking bench for id_issue_ctrl.
// The reference model holds:
//   - a per-register pending-write flag
//   - the number of flush cycles left
//   - whether the previous cycle left a valid instruction un-issued outside
//     a flush
// A negedge process compares every output against that model on every
// cycle. Directed sequences pin the model with literal values, and a
// randomized phase follows them.
// ----------------------------------------------------------------------------
module tb_id_issue_ctrl;

    localparam int NREGS     = 32;
    localparam int AW        = 5;
    localparam int FLUSH_CYC = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             i_if_valid;
    logic             o_id_ready;
    logic [AW-1:0]    i_rs1_addr, i_rs2_addr, i_rd_addr;
    logic             i_uses_rs1, i_uses_rs2, i_writes_rd;
    logic             o_issue_valid;
    logic             i_ex_ready;
    logic             i_wb_wr_reg_en;
    logic [AW-1:0]    i_wb_wr_reg_addr;
    logic             i_flush;
    logic             o_stall;
    logic [NREGS-1:0] o_busy_vec;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    id_issue_ctrl #(.NREGS(NREGS), .AW(AW), .FLUSH_CYC(FLUSH_CYC)) dut (
        .clk              (clk),
        .rst              (rst),
        .i_if_valid       (i_if_valid),
        .o_id_ready       (o_id_ready),
        .i_rs1_addr       (i_rs1_addr),
        .i_rs2_addr       (i_rs2_addr),
        .i_rd_addr        (i_rd_addr),
        .i_uses_rs1       (i_uses_rs1),
        .i_uses_rs2       (i_uses_rs2),
        .i_writes_rd      (i_writes_rd),
        .o_issue_valid    (o_issue_valid),
        .i_ex_ready       (i_ex_ready),
        .i_wb_wr_reg_en   (i_wb_wr_reg_en),
        .i_wb_wr_reg_addr (i_wb_wr_reg_addr),
        .i_flush          (i_flush),
        .o_stall          (o_stall),
        .o_busy_vec       (o_busy_vec)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    bit pending [NREGS];   // register has an outstanding write
    int flush_left = 0;    // flush cycles still to spend
    bit held_back  = 0;    // last cycle had a valid instruction that did not issue

    function automatic bit reg_blocked(input logic [AW-1:0] a);
        bit b;
        b = pending[a];
`ifdef ID_ISSUE_WB_BYPASS_EN
        if (i_wb_wr_reg_en && i_wb_wr_reg_addr == a) b = 1'b0;
`endif
        return b;
    endfunction

    function automatic bit model_go();
        bit hz;
        hz = (i_uses_rs1 && reg_blocked(i_rs1_addr)) ||
             (i_uses_rs2 && reg_blocked(i_rs2_addr)) ||
             (i_writes_rd && reg_blocked(i_rd_addr));
        return !rst && flush_left == 0 && !hz && i_ex_ready && !i_flush;
    endfunction

    function automatic logic [NREGS-1:0] model_busy();
        logic [NREGS-1:0] v;
        for (int i = 0; i < NREGS; i++) v[i] = pending[i];
        return v;
    endfunction

    always @(posedge clk) begin
        bit go_now;
        go_now = model_go();
        if (rst) begin
            for (int i = 0; i < NREGS; i++) pending[i] = 1'b0;
            flush_left = 0;
            held_back  = 1'b0;
        end else begin
            held_back = (flush_left == 0) && i_if_valid && !go_now && !i_flush;
            if (i_flush)             flush_left = FLUSH_CYC;
            else if (flush_left > 0) flush_left = flush_left - 1;
            if (i_wb_wr_reg_en && i_wb_wr_reg_addr != 0)
                pending[i_wb_wr_reg_addr] = 1'b0;
            if (i_if_valid && go_now && i_writes_rd && i_rd_addr != 0)
                pending[i_rd_addr] = 1'b1;
        end
    end

    // Compare every output against the model once per cycle.
    always @(negedge clk) begin
        bit g;
        g = model_go();
        check("id_ready",    o_id_ready,    g);
        check("issue_valid", o_issue_valid, g && i_if_valid);
        check("stall",       o_stall,       !rst && held_back);
        check("busy_vec",    o_busy_vec,    rst ? '0 : model_busy());
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input bit v, input int r1, input bit u1, input int r2,
                             input bit u2, input int rd, input bit w);
        i_if_valid  = v;
        i_rs1_addr  = AW'(r1);
        i_uses_rs1  = u1;
        i_rs2_addr  = AW'(r2);
        i_uses_rs2  = u2;
        i_rd_addr   = AW'(rd);
        i_writes_rd = w;
    endtask

    initial begin
        rst = 1'b1;
        i_ex_ready = 1'b1;
        i_wb_wr_reg_en = 1'b0;
        i_wb_wr_reg_addr = '0;
        i_flush = 1'b0;
        set_instr(1, 5, 1, 0, 0, 0, 0);

        // Two reset cycles; all outputs are held low even with valid input.
        tick();
        #2 check("rst_ready", o_id_ready, 1'b0);
        check("rst_issue", o_issue_valid, 1'b0);
        tick();
        rst = 1'b0;

        // 1: hazard-free instruction issues in the same cycle.
        #2 check("t1_issue", o_issue_valid, 1'b1);
        check("t1_busy", o_busy_vec, 32'h0);
        tick();

        // 2: RAW on x5 released by the WB write.
        set_instr(1, 0, 0, 0, 0, 5, 1);
        #2 check("t2_issue_wr", o_issue_valid, 1'b1);
        tick();
        set_instr(1, 5, 1, 0, 0, 0, 0);
        #2 check("t2_raw_block", o_issue_valid, 1'b0);
        check("t2_busy5", o_busy_vec, 32'h20);
        tick();
        #2 check("t2_stall", o_stall, 1'b1);
        tick();
        i_wb_wr_reg_en = 1'b1;
        i_wb_wr_reg_addr = 5'd5;
`ifdef ID_ISSUE_WB_BYPASS_EN
        #2 check("t2_wb_issue", o_issue_valid, 1'b1);
`else
        #2 check("t2_wb_issue", o_issue_valid, 1'b0);
`endif
        tick();
        i_wb_wr_reg_en = 1'b0;
`ifdef ID_ISSUE_WB_BYPASS_EN
        i_if_valid = 1'b0;
`else
        #2 check("t2_late_issue", o_issue_valid, 1'b1);
`endif
        #0 check("t2_busy_clr", o_busy_vec, 32'h0);
        tick();

        // 3: rd=x0 never becomes busy; x0 sources never stall.
        set_instr(1, 0, 0, 0, 0, 0, 1);
        #2 check("t3_x0_issue", o_issue_valid, 1'b1);
        tick();
        i_if_valid = 1'b0;
        #2 check("t3_x0_busy", o_busy_vec, 32'h0);
        for (int r = 1; r < NREGS; r++) begin
            set_instr(1, 0, 0, 0, 0, r, 1);
            tick();
        end
        set_instr(1, 0, 1, 0, 1, 0, 0);
        #2 check("t3_all_busy", o_busy_vec, 32'hFFFF_FFFE);
        check("t3_x0_src_issue", o_issue_valid, 1'b1);
        check("t3_no_stall", o_stall, 1'b0);
        tick();

        // 4: flush while stalled on rs2=x9; busy bits survive the flush.
        set_instr(1, 0, 0, 9, 1, 0, 0);
        #2 check("t4_block", o_issue_valid, 1'b0);
        tick();
        #2 check("t4_stall", o_stall, 1'b1);
        i_flush = 1'b1;
        #1 check("t4_t0_ready", o_id_ready, 1'b0);
        tick();
        i_flush = 1'b0;
        set_instr(0, 0, 0, 0, 0, 0, 0);
        #2 check("t4_t1_ready", o_id_ready, 1'b0);
        check("t4_t1_stall", o_stall, 1'b0);
        tick();
        #2 check("t4_t2_ready", o_id_ready, 1'b0);
        tick();
        #2 check("t4_t3_ready", o_id_ready, 1'b1);
        check("t4_busy9", o_busy_vec[9], 1'b1);
        tick();

        rst = 1'b1;
        tick();
        #2 check("rst2_busy", o_busy_vec, 32'h0);
        tick();
        rst = 1'b0;

        // 5: EX back-pressure for three cycles.
        set_instr(1, 3, 1, 0, 0, 0, 0);
        i_ex_ready = 1'b0;
        #2 check("t5_c1_issue", o_issue_valid, 1'b0);
        tick();
        #2 check("t5_c2_stall", o_stall, 1'b1);
        check("t5_c2_busy", o_busy_vec, 32'h0);
        tick();
        #2 check("t5_c3_issue", o_issue_valid, 1'b0);
        tick();
        i_ex_ready = 1'b1;
        #2 check("t5_release", o_issue_valid, 1'b1);
        tick();

        // 6: WB of x7 and a new writer of x7 in the same cycle.
        set_instr(1, 0, 0, 0, 0, 7, 1);
        tick();
        i_wb_wr_reg_en = 1'b1;
        i_wb_wr_reg_addr = 5'd7;
`ifdef ID_ISSUE_WB_BYPASS_EN
        #2 check("t6_issue", o_issue_valid, 1'b1);
`else
        #2 check("t6_issue", o_issue_valid, 1'b0);
`endif
        tick();
        i_wb_wr_reg_en = 1'b0;
        i_if_valid = 1'b0;
`ifdef ID_ISSUE_WB_BYPASS_EN
        #2 check("t6_set_wins", o_busy_vec[7], 1'b1);
`else
        #2 check("t6_cleared", o_busy_vec[7], 1'b0);
`endif
        tick();

        // Randomized phase; the negedge compare process checks every cycle.
        for (int n = 0; n < 3000; n++) begin
            rst              = ($urandom_range(0, 99) == 0);
            i_flush          = ($urandom_range(0, 99) < 4);
            i_ex_ready       = ($urandom_range(0, 99) < 80);
            i_wb_wr_reg_en   = ($urandom_range(0, 99) < 40);
            i_wb_wr_reg_addr = AW'($urandom_range(0, 7));
            set_instr($urandom_range(0, 99) < 80,
                      $urandom_range(0, 7), $urandom_range(0, 1),
                      $urandom_range(0, 7), $urandom_range(0, 1),
                      $urandom_range(0, 7), $urandom_range(0, 1));
            tick();
        end

        #3 $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
